clkk_i2c_master: RTL and testbench

Single-transaction I2C write master for configuring the ES9821Q. A rising edge on `i2c_start` makes the block write one register: START, 7-bit slave address + W, register address, data byte, STOP. It reports completion and any missing acknowledge. It sits between the board-level control FSM and the open-drain SCL/SDA pins.

---
 rtl/clkk_pkg.sv | 36 +++
 rtl/clkk_tick_gen.sv | 41 ++++
 rtl/clkk_i2c_master.sv | 197 +++++++++++++++++++
 tb/tb_clkk_i2c_master.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clkk_pkg.sv
// Shared definitions for the ES9821Q configuration I2C master.
// Holds the transaction state encoding, the phase lengths measured in
// quarter-bit ticks, and small helpers that split the quarter counter
// into a bit slot and a phase within that slot.
package clkk_pkg;

    typedef enum logic [2:0] {
        IDLE             = 3'd0,
        START            = 3'd1,
        WRITE_SLAVE_ADDR = 3'd2,
        WRITE_REG_ADDR   = 3'd3,
        WRITE_DATA       = 3'd4,
        STOP             = 3'd5,
        DONE             = 3'd6
    } i2c_state_t;

    // A byte phase is 8 data slots plus one ACK slot, 4 quarters each.
    localparam logic [5:0] BYTE_QUARTERS = 6'd36;
    // START and STOP conditions each last one slot.
    localparam logic [5:0] COND_QUARTERS = 6'd4;
    localparam logic [3:0] ACK_SLOT      = 4'd8;

    localparam logic [1:0] PH_Q0 = 2'd0;
    localparam logic [1:0] PH_Q1 = 2'd1;
    localparam logic [1:0] PH_Q2 = 2'd2;
    localparam logic [1:0] PH_Q3 = 2'd3;

    function automatic logic [3:0] slot_of(input logic [5:0] cnt);
        return cnt[5:2];
    endfunction

    function automatic logic [1:0] phase_of(input logic [5:0] cnt);
        return cnt[1:0];
    endfunction

endpackage

// File: rtl/clkk_tick_gen.sv
// Quarter-bit timebase for the I2C master.
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset
//   tick      - one-cycle strobe on the last count of each divider period
//   drive_clk - square wave at the tick rate, high for the first half period
module clkk_tick_gen #(
    parameter int unsigned DIV = 125
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic drive_clk
);

    localparam int unsigned   CW   = (DIV > 32'd1) ? $clog2(DIV) : 32'd1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 32'd1);
    localparam logic [CW-1:0] HALF = CW'(DIV / 32'd2);

    logic [CW-1:0] div_cnt_r;
    logic          drive_clk_r;

    // Free-running divider and the registered half-period reference clock
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_r   <= '0;
            drive_clk_r <= 1'b0;
        end else begin
            if (div_cnt_r == LAST) begin
                div_cnt_r <= '0;
            end else begin
                div_cnt_r <= div_cnt_r + CW'(1);
            end
            drive_clk_r <= (div_cnt_r < HALF);
        end
    end

    assign tick      = (div_cnt_r == LAST);
    assign drive_clk = drive_clk_r;

endmodule

// File: rtl/clkk_i2c_master.sv
// Single-register I2C write master: START, {addr,W}, register, data, STOP.
// Ports:
//   sys_clk       - system clock, everything on the rising edge
//   rst_n         - synchronous reset, asserted while HIGH (legacy name)
//   i2c_start     - transaction request, rising edge only
//   i2c_done      - one-cycle pulse after STOP or after a NACK abort
//   i2c_ack       - sticky NACK error flag, cleared by the next accepted start
//   scl           - push-pull I2C clock, idles high
//   sda           - open-drain data line, driven low or released
//   i2c_drive_clk - quarter-bit reference clock
module clkk_i2c_master
    import clkk_pkg::*;
#(
    parameter int unsigned SYS_CLK_FREQ = 50_000_000,
    parameter int unsigned I2C_CLK      = 100_000,
    parameter logic [6:0]  SLAVE_ADDR   = 7'h40,
    parameter logic [7:0]  REG_ADDR     = 8'h00,
    parameter logic [7:0]  REG_DATA     = 8'h00
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic i2c_start,
    output logic i2c_done,
    output logic i2c_ack,
    output logic scl,
    inout  wire  sda,
    output logic i2c_drive_clk
);

    localparam int unsigned DIV = SYS_CLK_FREQ / (32'd4 * I2C_CLK);
    localparam logic [5:0] BYTE_LAST = BYTE_QUARTERS - 6'd1;
    localparam logic [5:0] COND_LAST = COND_QUARTERS - 6'd1;

    i2c_state_t  state_r;
    logic [5:0]  cnt_r;
    logic [7:0]  shift_r;
    logic        start_d1_r;
    logic        start_d2_r;
    logic        pending_r;
    logic        nack_r;
    logic        scl_r;
    logic        sda_oe_r;
    logic        done_r;
    logic        ack_r;
    logic        tick_s;
    logic        start_rise_s;

    clkk_tick_gen #(.DIV(DIV)) u_tick (
        .clk       (sys_clk),
        .rst       (rst_n),
        .tick      (tick_s),
        .drive_clk (i2c_drive_clk)
    );

    assign start_rise_s = start_d1_r & ~start_d2_r;

    // Transaction sequencer: each quarter tick performs one step of the current bus phase
    always_ff @(posedge sys_clk) begin
        if (rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= 6'd0;
            shift_r    <= 8'h00;
            start_d1_r <= 1'b0;
            start_d2_r <= 1'b0;
            pending_r  <= 1'b0;
            nack_r     <= 1'b0;
            scl_r      <= 1'b1;
            sda_oe_r   <= 1'b0;
            done_r     <= 1'b0;
            ack_r      <= 1'b0;
        end else begin
            start_d1_r <= i2c_start;
            start_d2_r <= start_d1_r;
            done_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    scl_r    <= 1'b1;
                    sda_oe_r <= 1'b0;
                    // A request is latched here and launched on the next tick,
                    // so the bus always starts on a quarter boundary.
                    if (tick_s && pending_r) begin
                        state_r   <= START;
                        cnt_r     <= 6'd0;
                        shift_r   <= {SLAVE_ADDR, 1'b0};
                        ack_r     <= 1'b0;
                        nack_r    <= 1'b0;
                        pending_r <= 1'b0;
                    end else if (start_rise_s) begin
                        pending_r <= 1'b1;
                    end else begin
                        pending_r <= pending_r;
                    end
                end
                START: begin
                    if (tick_s) begin
                        case (phase_of(cnt_r))
                            PH_Q0: begin
                                scl_r    <= 1'b1;
                                sda_oe_r <= 1'b0;
                            end
                            PH_Q1:   sda_oe_r <= 1'b1;
                            PH_Q2:   scl_r    <= 1'b0;
                            default: ;
                        endcase
                        if (cnt_r == COND_LAST) begin
                            state_r <= WRITE_SLAVE_ADDR;
                            cnt_r   <= 6'd0;
                        end else begin
                            cnt_r <= cnt_r + 6'd1;
                        end
                    end
                end
                WRITE_SLAVE_ADDR, WRITE_REG_ADDR, WRITE_DATA: begin
                    if (tick_s) begin
                        case (phase_of(cnt_r))
                            PH_Q0: begin
                                scl_r <= 1'b0;
                                if (slot_of(cnt_r) == ACK_SLOT) begin
                                    sda_oe_r <= 1'b0;
                                end else begin
                                    sda_oe_r <= ~shift_r[7];
                                    shift_r  <= {shift_r[6:0], 1'b0};
                                end
                            end
                            PH_Q1: scl_r <= 1'b1;
                            PH_Q2: begin
                                scl_r <= 1'b1;
                                if (slot_of(cnt_r) == ACK_SLOT) begin
                                    nack_r <= sda;
                                    ack_r  <= ack_r | sda;
                                end else begin
                                    nack_r <= nack_r;
                                end
                            end
                            PH_Q3:   scl_r <= 1'b0;
                            default: ;
                        endcase
                        if (cnt_r == BYTE_LAST) begin
                            cnt_r <= 6'd0;
                            if (nack_r) begin
                                state_r <= STOP;
                            end else begin
                                case (state_r)
                                    WRITE_SLAVE_ADDR: begin
                                        state_r <= WRITE_REG_ADDR;
                                        shift_r <= REG_ADDR;
                                    end
                                    WRITE_REG_ADDR: begin
                                        state_r <= WRITE_DATA;
                                        shift_r <= REG_DATA;
                                    end
                                    default: state_r <= STOP;
                                endcase
                            end
                        end else begin
                            cnt_r <= cnt_r + 6'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick_s) begin
                        case (phase_of(cnt_r))
                            PH_Q0: begin
                                scl_r    <= 1'b0;
                                sda_oe_r <= 1'b1;
                            end
                            PH_Q1:   scl_r    <= 1'b1;
                            PH_Q2:   sda_oe_r <= 1'b0;
                            default: ;
                        endcase
                        if (cnt_r == COND_LAST) begin
                            state_r <= DONE;
                            cnt_r   <= 6'd0;
                        end else begin
                            cnt_r <= cnt_r + 6'd1;
                        end
                    end
                end
                DONE: begin
                    done_r  <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    state_r  <= IDLE;
                    scl_r    <= 1'b1;
                    sda_oe_r <= 1'b0;
                end
            endcase
        end
    end

    assign sda      = sda_oe_r ? 1'b0 : 1'bz;
    assign scl      = scl_r;
    assign i2c_done = done_r;
    assign i2c_ack  = ack_r;

endmodule

// File: tb/tb_clkk_i2c_master.sv
`timescale 1ns/1ps
module tb_clkk_i2c_master;

    localparam int DIV   = 125;
    localparam int LIMIT = 120 * DIV;

    logic sys_clk       = 1'b0;
    logic rst_n         = 1'b1;
    logic i2c_start     = 1'b0;
    logic i2c_done;
    logic i2c_ack;
    logic scl;
    logic i2c_drive_clk;
    wire  sda;

    pullup (sda);

    // Slave model state (written only by the slave process)
    logic       slave_pull = 1'b0;
    logic       prev_scl   = 1'b1;
    logic       prev_sda   = 1'b1;
    logic       in_xfer    = 1'b0;
    logic [7:0] shreg      = 8'h00;
    int         bitcnt     = 0;
    int         byte_idx   = 0;
    int         starts     = 0;
    int         stops      = 0;
    logic [7:0] rx_q [$];

    // Written only by the stimulus process
    logic [2:0] ack_mask = 3'b111;

    assign sda = slave_pull ? 1'b0 : 1'bz;

    clkk_i2c_master #(
        .SLAVE_ADDR (7'h40),
        .REG_ADDR   (8'hA5),
        .REG_DATA   (8'h3C)
    ) dut (
        .sys_clk       (sys_clk),
        .rst_n         (rst_n),
        .i2c_start     (i2c_start),
        .i2c_done      (i2c_done),
        .i2c_ack       (i2c_ack),
        .scl           (scl),
        .sda           (sda),
        .i2c_drive_clk (i2c_drive_clk)
    );

    always #5 sys_clk = ~sys_clk;

    // Behavioural I2C slave: decodes START/STOP, shifts bytes on SCL rise,
    // acknowledges byte i when ack_mask[i] is set.
    always @(negedge sys_clk) begin
        logic s;
        s = sda;
        if (rst_n) begin
            in_xfer    = 1'b0;
            slave_pull = 1'b0;
            bitcnt     = 0;
            prev_scl   = 1'b1;
            prev_sda   = 1'b1;
        end else begin
            if (prev_scl && scl) begin
                if (prev_sda && !s) begin
                    starts++;
                    in_xfer  = 1'b1;
                    bitcnt   = 0;
                    byte_idx = 0;
                end else if (!prev_sda && s) begin
                    if (in_xfer) stops++;
                    in_xfer    = 1'b0;
                    slave_pull = 1'b0;
                end
            end
            if (in_xfer && !prev_scl && scl) begin
                if (bitcnt < 8) shreg = {shreg[6:0], s};
                bitcnt++;
                if (bitcnt == 8) rx_q.push_back(shreg);
            end
            if (in_xfer && prev_scl && !scl) begin
                if (bitcnt == 8) begin
                    slave_pull = (byte_idx < 3) ? ack_mask[byte_idx] : 1'b0;
                end else if (bitcnt == 9) begin
                    slave_pull = 1'b0;
                    bitcnt     = 0;
                    byte_idx++;
                end
            end
            prev_scl = scl;
            prev_sda = s;
        end
    end

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0] mask;
        int         exp_n;
        logic       exp_ack;
        int         exp_ticks;
    } vec_t;

    vec_t       tbl [3];
    logic [7:0] exp_bytes [3];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic check_range(input string name, input int got, input int lo, input int hi);
        tests++;
        if (got < lo || got > hi) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // Reference model: bytes go out until the first unacknowledged one.
    function automatic int model_bytes(input logic [2:0] m);
        for (int i = 0; i < 3; i++) begin
            if (!m[i]) return i + 1;
        end
        return 3;
    endfunction

    task automatic run_and_check(input logic [2:0] mask, input int exp_n,
                                 input logic exp_ack, input int exp_ticks);
        int   lat;
        int   s0;
        int   p0;
        int   r0;
        bit   seen;
        bit   got_done;
        logic ack_first;
        ack_mask  = mask;
        s0        = starts;
        p0        = stops;
        r0        = rx_q.size();
        i2c_start = 1'b0;
        repeat (4) @(negedge sys_clk);
        i2c_start = 1'b1;
        lat       = 0;
        seen      = 1'b0;
        got_done  = 1'b0;
        ack_first = 1'bx;
        while (!got_done && lat < LIMIT) begin
            @(negedge sys_clk);
            lat++;
            if (!seen && starts != s0) begin
                seen      = 1'b1;
                ack_first = i2c_ack;
            end
            if (i2c_done) got_done = 1'b1;
        end
        check("done_seen", 32'(got_done), 32'd1);
        check_range("done_latency", lat, exp_ticks * DIV, exp_ticks * DIV + DIV + 4);
        @(negedge sys_clk);
        check("done_pulse_width", 32'(i2c_done), 32'd0);
        check("ack_cleared_at_start", 32'(ack_first), 32'd0);
        check("ack_flag", 32'(i2c_ack), 32'(exp_ack));
        check("start_count", 32'(starts - s0), 32'd1);
        check("stop_count", 32'(stops - p0), 32'd1);
        check("byte_count", 32'(rx_q.size() - r0), 32'(exp_n));
        for (int i = 0; i < exp_n; i++) begin
            if (r0 + i < rx_q.size()) check("byte_value", 32'(rx_q[r0 + i]), 32'(exp_bytes[i]));
        end
    endtask

    initial begin
        int         hi;
        int         lo;
        int         w;
        int         dcount;
        int         scl_low;
        int         s0;
        int         r0;
        logic [2:0] m;
        int         n;

        exp_bytes[0] = 8'h80;
        exp_bytes[1] = 8'hA5;
        exp_bytes[2] = 8'h3C;
        tbl[0] = '{mask: 3'b111, exp_n: 3, exp_ack: 1'b0, exp_ticks: 116};
        tbl[1] = '{mask: 3'b000, exp_n: 1, exp_ack: 1'b1, exp_ticks: 44};
        tbl[2] = '{mask: 3'b001, exp_n: 2, exp_ack: 1'b1, exp_ticks: 80};

        // Reset state
        rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        check("rst_scl", 32'(scl), 32'd1);
        check("rst_sda", 32'(sda), 32'd1);
        check("rst_done", 32'(i2c_done), 32'd0);
        check("rst_ack", 32'(i2c_ack), 32'd0);
        check("rst_drive_clk", 32'(i2c_drive_clk), 32'd0);
        rst_n = 1'b0;

        // Reference clock shape
        w = 0;
        while (i2c_drive_clk !== 1'b0 && w < 400) begin @(negedge sys_clk); w++; end
        while (i2c_drive_clk !== 1'b1 && w < 400) begin @(negedge sys_clk); w++; end
        hi = 0;
        while (i2c_drive_clk === 1'b1 && hi < 400) begin @(negedge sys_clk); hi++; end
        lo = 0;
        while (i2c_drive_clk === 1'b0 && lo < 400) begin @(negedge sys_clk); lo++; end
        check("drive_clk_high", 32'(hi), 32'd62);
        check("drive_clk_period", 32'(hi + lo), 32'd125);

        // Table-driven transactions
        for (int i = 0; i < 3; i++) begin
            run_and_check(tbl[i].mask, tbl[i].exp_n, tbl[i].exp_ack, tbl[i].exp_ticks);
        end

        // i2c_start still held high: nothing new may happen
        s0     = starts;
        dcount = 0;
        repeat (12 * DIV) begin
            @(negedge sys_clk);
            if (i2c_done) dcount++;
        end
        check("held_high_no_start", 32'(starts - s0), 32'd0);
        check("held_high_no_done", 32'(dcount), 32'd0);

        // Re-raise with a random acknowledge pattern; i2c_ack is 1 from before
        m = 3'($urandom_range(0, 7));
        n = model_bytes(m);
        run_and_check(m, n, ~m[n - 1], 4 + 36 * n + 4);

        // Reset in the middle of the register-address byte
        ack_mask  = 3'b111;
        r0        = rx_q.size();
        i2c_start = 1'b0;
        repeat (4) @(negedge sys_clk);
        i2c_start = 1'b1;
        w = 0;
        while (!(rx_q.size() == r0 + 1 && bitcnt >= 3) && w < LIMIT) begin
            @(negedge sys_clk);
            w++;
        end
        check("reached_reg_addr", 32'(w < LIMIT), 32'd1);
        rst_n     = 1'b1;
        i2c_start = 1'b0;
        @(negedge sys_clk);
        check("midrst_scl", 32'(scl), 32'd1);
        check("midrst_sda", 32'(sda), 32'd1);
        check("midrst_done", 32'(i2c_done), 32'd0);
        check("midrst_ack", 32'(i2c_ack), 32'd0);
        repeat (2) @(negedge sys_clk);
        rst_n   = 1'b0;
        dcount  = 0;
        scl_low = 0;
        repeat (3 * DIV) begin
            @(negedge sys_clk);
            if (i2c_done) dcount++;
            if (!scl) scl_low++;
        end
        check("midrst_no_done", 32'(dcount), 32'd0);
        check("midrst_bus_idle", 32'(scl_low), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
